ahb_lite_arbiter: RTL and testbench

//   Shares the single AHB-Lite memory slave between NUM_M bus masters.
//   - Round-robin arbitration with burst-aware and lock-aware grant handover.
//   - Muxes the owner's address/control onto the slave bus in the address phase.
//   - Muxes the data-phase owner's write data onto the slave bus in the data phase.
//   - Sits between the master ports and the slave, which is driven by hsel/haddr/.../hwdata and returns hready.

---
 rtl/ahb_lite_arbiter.sv | 147 ++++++++++++++
 tb/tb_ahb_lite_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_arbiter.sv
// rtl/ahb_lite_arbiter.sv - round-robin AHB-Lite arbiter and bus mux for NUM_M masters sharing one slave
module ahb_lite_arbiter #(
    parameter int NUM_M  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                     hclk,
    input  logic                     hreset,
    input  logic [NUM_M-1:0]         m_hbusreq,
    input  logic [NUM_M-1:0]         m_hlock,
    input  logic [NUM_M*ADDR_W-1:0]  m_haddr,
    input  logic [NUM_M*2-1:0]       m_htrans,
    input  logic [NUM_M-1:0]         m_hwrite,
    input  logic [NUM_M*3-1:0]       m_hsize,
    input  logic [NUM_M*3-1:0]       m_hburst,
    input  logic [NUM_M*DATA_W-1:0]  m_hwdata,
    input  logic                     hready,
    output logic [NUM_M-1:0]         hgrant,
    output logic [1:0]               hmaster,
    output logic                     hsel,
    output logic [ADDR_W-1:0]        haddr,
    output logic [1:0]               htrans,
    output logic                     hwrite,
    output logic [2:0]               hsize,
    output logic [2:0]               hburst,
    output logic                     hmastlock,
    output logic [DATA_W-1:0]        hwdata
);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_BUSY   = 2'b01;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;

    // Only 2..4 masters fit the 2-bit hmaster encoding.
    if (NUM_M < 2 || NUM_M > 4) begin : g_num_m_check
        $error("ahb_lite_arbiter: NUM_M must be in 2..4");
    end

    logic [1:0] hmaster_q, hmaster_d;     // address-phase owner
    logic [1:0] dmaster_q, dmaster_d;     // data-phase owner
    logic       hmastlock_q, hmastlock_d;
    logic [3:0] cnt_q, cnt_d;             // beats still owed in a fixed-length burst

    logic [1:0] own_trans;
    logic [2:0] own_burst;
    logic       own_lock;
    logic [3:0] burst_len_m1;
    logic       burst_fixed;
    logic       handover;
    logic [1:0] winner;

    assign own_trans = m_htrans[2*int'(hmaster_q) +: 2];
    assign own_burst = m_hburst[3*int'(hmaster_q) +: 3];
    assign own_lock  = m_hlock[hmaster_q];

    // Beats remaining after a NONSEQ of the owner's burst type; 0 for SINGLE/INCR.
    always_comb begin
        burst_len_m1 = 4'd0;
        case (own_burst[2:1])
            2'b01:   burst_len_m1 = 4'd3;
            2'b10:   burst_len_m1 = 4'd7;
            2'b11:   burst_len_m1 = 4'd15;
            default: burst_len_m1 = 4'd0;
        endcase
    end

    assign burst_fixed = (own_burst[2:1] != 2'b00);

    // Beat counter next state: only accepted owner transfers move it.
    always_comb begin
        cnt_d = cnt_q;
        if (hready) begin
            case (own_trans)
                TRANS_NONSEQ: cnt_d = burst_len_m1;
                TRANS_SEQ:    cnt_d = (burst_fixed && cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
                TRANS_BUSY:   cnt_d = cnt_q;
                default:      cnt_d = 4'd0;
            endcase
        end
    end

    assign handover = hready && !own_lock && (cnt_d == 4'd0) && (own_trans != TRANS_BUSY);

    // Round-robin scan from owner+1; the owner is looked at last; master 0 if nobody asks.
    always_comb begin
        int   idx;
        logic found;
        winner = 2'd0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 1; i <= NUM_M; i++) begin
            idx = int'(hmaster_q) + i;
            if (idx >= NUM_M) begin
                idx = idx - NUM_M;
            end
            if (!found && m_hbusreq[idx]) begin
                winner = 2'(idx);
                found  = 1'b1;
            end
        end
    end

    // Grant, data-phase owner and lock flag advance only on accepted edges.
    always_comb begin
        hmaster_d   = hmaster_q;
        dmaster_d   = dmaster_q;
        hmastlock_d = hmastlock_q;
        if (hready) begin
            dmaster_d = hmaster_q;
            if (handover) begin
                hmaster_d = winner;
            end
            hmastlock_d = m_hlock[hmaster_d];
        end
    end

    // State registers with synchronous reset back to the default master.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            hmaster_q   <= 2'd0;
            dmaster_q   <= 2'd0;
            hmastlock_q <= 1'b0;
            cnt_q       <= 4'd0;
        end else begin
            hmaster_q   <= hmaster_d;
            dmaster_q   <= dmaster_d;
            hmastlock_q <= hmastlock_d;
            cnt_q       <= cnt_d;
        end
    end

    for (genvar g = 0; g < NUM_M; g++) begin : g_grant
        assign hgrant[g] = (hmaster_q == 2'(g));
    end

    assign hmaster   = hmaster_q;
    assign hmastlock = hmastlock_q;
    assign haddr     = m_haddr[ADDR_W*int'(hmaster_q) +: ADDR_W];
    assign htrans    = own_trans;
    assign hsel      = own_trans[1];
    assign hwrite    = m_hwrite[hmaster_q];
    assign hsize     = m_hsize[3*int'(hmaster_q) +: 3];
    assign hburst    = own_burst;
    assign hwdata    = m_hwdata[DATA_W*int'(dmaster_q) +: DATA_W];

endmodule

// File: tb/tb_ahb_lite_arbiter.sv
// tb/tb_ahb_lite_arbiter.sv - self-checking bench for ahb_lite_arbiter with a transaction-level model
module tb_ahb_lite_arbiter;

    localparam int N = 2;
    localparam logic [1:0] IDLE = 2'b00, NSEQ = 2'b10, SEQ = 2'b11;
    localparam logic [2:0] SINGLE = 3'b000, INCR4 = 3'b011, INCR8 = 3'b101, WRAP16 = 3'b110;

    logic        hclk = 1'b0;
    logic        hreset;
    logic        hready;
    logic        req  [N];
    logic        lock [N];
    logic [31:0] addr [N];
    logic [1:0]  trans[N];
    logic [2:0]  burst[N];
    logic [31:0] wdata[N];

    logic [N-1:0]    m_hbusreq, m_hlock, m_hwrite;
    logic [N*32-1:0] m_haddr, m_hwdata;
    logic [N*2-1:0]  m_htrans;
    logic [N*3-1:0]  m_hsize, m_hburst;

    logic [N-1:0] hgrant;
    logic [1:0]   hmaster, htrans;
    logic         hsel, hwrite, hmastlock;
    logic [31:0]  haddr, hwdata;
    logic [2:0]   hsize, hburst;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign m_hbusreq[g]          = req[g];
        assign m_hlock[g]            = lock[g];
        assign m_hwrite[g]           = 1'b1;
        assign m_haddr[g*32 +: 32]   = addr[g];
        assign m_hwdata[g*32 +: 32]  = wdata[g];
        assign m_htrans[g*2 +: 2]    = trans[g];
        assign m_hsize[g*3 +: 3]     = 3'b010;
        assign m_hburst[g*3 +: 3]    = burst[g];
    end

    ahb_lite_arbiter #(.NUM_M(N), .ADDR_W(32), .DATA_W(32)) dut (
        .hclk(hclk), .hreset(hreset), .m_hbusreq(m_hbusreq), .m_hlock(m_hlock),
        .m_haddr(m_haddr), .m_htrans(m_htrans), .m_hwrite(m_hwrite), .m_hsize(m_hsize),
        .m_hburst(m_hburst), .m_hwdata(m_hwdata), .hready(hready), .hgrant(hgrant),
        .hmaster(hmaster), .hsel(hsel), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
        .hsize(hsize), .hburst(hburst), .hmastlock(hmastlock), .hwdata(hwdata)
    );

    always #5 hclk = ~hclk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: who owns the address phase, who owns the data phase, beats still owed.
    int m_owner = 0, m_downer = 0, m_left = 0;
    bit m_lock = 1'b0;

    function automatic int burst_beats(input logic [2:0] b);
        if (b >= 3'd6) return 16;
        if (b >= 3'd4) return 8;
        if (b >= 3'd2) return 4;
        return 0;
    endfunction

    always @(posedge hclk) begin
        if (hreset) begin
            m_owner = 0; m_downer = 0; m_left = 0; m_lock = 1'b0;
        end else if (hready) begin
            int beats;
            bit open;
            beats = burst_beats(burst[m_owner]);
            if (trans[m_owner] == NSEQ)
                m_left = (beats > 0) ? beats - 1 : 0;
            else if (trans[m_owner] == SEQ)
                m_left = (beats > 0 && m_left > 0) ? m_left - 1 : 0;
            else if (trans[m_owner] == IDLE)
                m_left = 0;
            open = !lock[m_owner] && m_left == 0 && trans[m_owner] != 2'b01;
            m_downer = m_owner;
            if (open) begin
                int nxt;
                nxt = 0;
                for (int k = N; k >= 1; k--)
                    if (req[(m_owner + k) % N]) nxt = (m_owner + k) % N;
                m_owner = nxt;
            end
            m_lock = lock[m_owner];
        end
    end

    // Every cycle: the muxed bus must match the model's owners.
    always @(negedge hclk) begin
        if (cmp_en) begin
            chk("hgrant",    64'(hgrant),    64'(1 << m_owner));
            chk("hmaster",   64'(hmaster),   64'(m_owner));
            chk("hmastlock", 64'(hmastlock), 64'(m_lock));
            chk("haddr",     64'(haddr),     64'(addr[m_owner]));
            chk("htrans",    64'(htrans),    64'(trans[m_owner]));
            chk("hsel",      64'(hsel),      64'(trans[m_owner][1]));
            chk("hburst",    64'(hburst),    64'(burst[m_owner]));
            chk("hwdata",    64'(hwdata),    64'(wdata[m_downer]));
        end
    end

    task automatic tick();
        @(posedge hclk);
        #2;
    endtask

    task automatic drv(input int m, input logic r, input logic l, input logic [1:0] t,
                       input logic [2:0] b, input logic [31:0] a, input logic [31:0] d);
        req[m] = r; lock[m] = l; trans[m] = t; burst[m] = b; addr[m] = a; wdata[m] = d;
    endtask

    task automatic idle_all();
        drv(0, 1'b0, 1'b0, IDLE, SINGLE, 32'h0, 32'h0);
        drv(1, 1'b0, 1'b0, IDLE, SINGLE, 32'h0, 32'h0);
    endtask

    initial begin
        hready = 1'b1;
        hreset = 1'b1;
        idle_all();
        drv(0, 1'b0, 1'b0, NSEQ, SINGLE, 32'h100, 32'hA0);
        tick();
        cmp_en = 1'b1;
        tick();
        chk("rst_hgrant", 64'(hgrant), 64'h1);
        chk("rst_hmaster", 64'(hmaster), 64'h0);
        chk("rst_hmastlock", 64'(hmastlock), 64'h0);
        chk("rst_hsel", 64'(hsel), 64'h1);

        // Two masters issuing SINGLE transfers back to back.
        drv(1, 1'b1, 1'b0, NSEQ, SINGLE, 32'h200, 32'hB1);
        req[0] = 1'b1;
        hreset = 1'b0;
        tick();
        chk("alt1_grant", 64'(hgrant), 64'h2);
        chk("alt1_haddr", 64'(haddr), 64'h200);
        chk("alt1_hwdata", 64'(hwdata), 64'hA0);
        tick();
        chk("alt2_grant", 64'(hgrant), 64'h1);
        chk("alt2_hwdata", 64'(hwdata), 64'hB1);
        tick();
        chk("alt3_grant", 64'(hgrant), 64'h2);

        // INCR4 from m0 must finish before m1 takes over.
        hreset = 1'b1; idle_all(); tick(); hreset = 1'b0;
        drv(1, 1'b1, 1'b0, NSEQ, SINGLE, 32'h200, 32'hB1);
        for (int b = 0; b < 4; b++) begin
            drv(0, 1'b1, 1'b0, (b == 0) ? NSEQ : SEQ, INCR4, 32'h10 + 32'(4 * b), 32'hC0 + 32'(b));
            tick();
            chk("incr4_grant", 64'(hgrant), (b == 3) ? 64'h2 : 64'h1);
        end
        chk("incr4_m1_addr", 64'(haddr), 64'h200);
        chk("incr4_m1_trans", 64'(htrans), 64'(NSEQ));
        drv(0, 1'b0, 1'b0, IDLE, SINGLE, 32'h0, 32'hC3);
        tick();

        // Locked SINGLE writes hold off m1.
        hreset = 1'b1; idle_all(); tick(); hreset = 1'b0;
        drv(1, 1'b1, 1'b0, NSEQ, SINGLE, 32'h200, 32'hB1);
        for (int b = 0; b < 3; b++) begin
            drv(0, 1'b1, 1'b1, NSEQ, SINGLE, 32'h40 + 32'(4 * b), 32'hE0 + 32'(b));
            tick();
            chk("lock_grant", 64'(hgrant), 64'h1);
            chk("lock_mastlock", 64'(hmastlock), 64'h1);
        end
        drv(0, 1'b0, 1'b0, IDLE, SINGLE, 32'h0, 32'hE2);
        tick();
        chk("unlock_grant", 64'(hgrant), 64'h2);
        chk("unlock_mastlock", 64'(hmastlock), 64'h0);

        // INCR8 with a three-cycle stall on beat 5.
        hreset = 1'b1; idle_all(); tick(); hreset = 1'b0;
        drv(1, 1'b1, 1'b0, NSEQ, SINGLE, 32'h200, 32'hB1);
        for (int b = 0; b < 8; b++) begin
            drv(0, 1'b1, 1'b0, (b == 0) ? NSEQ : SEQ, INCR8, 32'h80 + 32'(4 * b), 32'hD0 + 32'(b));
            if (b == 4) begin
                hready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    chk("stall_grant", 64'(hgrant), 64'h1);
                    chk("stall_hwdata", 64'(hwdata), 64'hD4);
                end
                hready = 1'b1;
            end
            tick();
            chk("incr8_grant", 64'(hgrant), (b == 7) ? 64'h2 : 64'h1);
        end

        // Reset in the middle of m1's WRAP16 burst.
        drv(0, 1'b0, 1'b0, IDLE, SINGLE, 32'h0, 32'h0);
        drv(1, 1'b1, 1'b0, NSEQ, WRAP16, 32'h300, 32'hF0);
        tick();
        chk("wrap_grant", 64'(hgrant), 64'h2);
        drv(1, 1'b1, 1'b0, SEQ, WRAP16, 32'h304, 32'hF1);
        hreset = 1'b1;
        tick();
        chk("midrst_grant", 64'(hgrant), 64'h1);
        chk("midrst_hmaster", 64'(hmaster), 64'h0);
        hreset = 1'b0;
        drv(1, 1'b0, 1'b0, IDLE, SINGLE, 32'h0, 32'h0);
        tick();
        chk("norq_grant", 64'(hgrant), 64'h1);
        drv(1, 1'b1, 1'b0, NSEQ, SINGLE, 32'h308, 32'hF2);
        tick();
        chk("rereq_grant", 64'(hgrant), 64'h2);
        tick();

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
